// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtraction controller: one full-subtractor slice per clock, LSB first.
// Optional zero/ovf result flags are enabled by defining SERIAL_SUB_FLAGS_EN.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] diff_nxt;
    logic             brw;
    logic             d;
    logic             nb;
    logic             last;
    logic [CW-1:0]    cnt;

    // The single subtractor slice, plus the diff value after this bit lands at the MSB.
    always_comb begin
        d        = sa[0] ^ sb[0] ^ brw;
        nb       = (~sa[0] & sb[0]) | (~sa[0] & brw) | (sb[0] & brw);
        diff_nxt = (diff >> 1) | (WIDTH'(d) << (WIDTH - 1));
        last     = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            sa        <= '0;
            sb        <= '0;
            brw       <= 1'b0;
            cnt       <= '0;
`ifdef SERIAL_SUB_FLAGS_EN
            zero      <= 1'b0;
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    if (in_valid) begin
                        sa       <= a;
                        sb       <= b;
                        brw      <= bin;
                        cnt      <= '0;
                        diff     <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sa   <= sa >> 1;
                    sb   <= sb >> 1;
                    brw  <= nb;
                    cnt  <= cnt + CW'(1);
                    diff <= diff_nxt;
                    if (last) begin
                        // brw here is the borrow into the MSB slice, nb the borrow out of it.
                        bout      <= nb;
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef SERIAL_SUB_FLAGS_EN
                        zero      <= (diff_nxt == '0);
                        ovf       <= brw ^ nb;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: WIDTH=8 scoreboard run plus a WIDTH=1 instance.
// Flag outputs are checked only when SERIAL_SUB_FLAGS_EN is defined.
module tb_serial_sub_ctrl;

    typedef struct {
        logic [7:0] diff;
        logic       bout;
        logic       zero;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       bin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] diff;
    logic       bout;
    logic       busy;
    logic       zero;
    logic       ovf;

    logic       c1_in_valid = 1'b0;
    logic       c1_in_ready;
    logic [0:0] c1_a = '0;
    logic [0:0] c1_b = '0;
    logic       c1_bin = 1'b0;
    logic       c1_out_valid;
    logic       c1_out_ready = 1'b0;
    logic [0:0] c1_diff;
    logic       c1_bout;
    logic       c1_busy;
    logic       c1_zero;
    logic       c1_ovf;

    int   evaluated = 0;
    int   failures = 0;
    exp_t sb_q[$];
    exp_t e;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .busy(busy)
`ifdef SERIAL_SUB_FLAGS_EN
        , .zero(zero), .ovf(ovf)
`endif
    );

    serial_sub_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(c1_in_valid), .in_ready(c1_in_ready),
        .a(c1_a), .b(c1_b), .bin(c1_bin), .out_valid(c1_out_valid), .out_ready(c1_out_ready),
        .diff(c1_diff), .bout(c1_bout), .busy(c1_busy)
`ifdef SERIAL_SUB_FLAGS_EN
        , .zero(c1_zero), .ovf(c1_ovf)
`endif
    );

`ifndef SERIAL_SUB_FLAGS_EN
    assign zero    = 1'b0;
    assign ovf     = 1'b0;
    assign c1_zero = 1'b0;
    assign c1_ovf  = 1'b0;
`endif

    // Arithmetic reference: unsigned result for diff/bout, signed range test for ovf.
    function automatic exp_t model(int w, longint ua, longint ub, logic bi);
        exp_t   r;
        longint mask = (64'sd1 <<< w) - 1;
        longint half = 64'sd1 <<< (w - 1);
        longint full = ua - ub - longint'(bi);
        longint sa = (ua >= half) ? ua - (64'sd1 <<< w) : ua;
        longint sbv = (ub >= half) ? ub - (64'sd1 <<< w) : ub;
        longint s = sa - sbv - longint'(bi);
        longint dm = full & mask;
        r.diff = 8'(dm);
        r.bout = (full < 0);
        r.zero = (dm == 0);
        r.ovf  = (s < -half) || (s > half - 1);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        evaluated++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic bi);
        int waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_before_accept", in_ready, 1);
        a = av;
        b = bv;
        bin = bi;
        in_valid = 1'b1;
        sb_q.push_back(model(8, longint'(av), longint'(bv), bi));
        @(negedge clk);
        in_valid = 1'b0;
        a = ~av;
        b = ~bv;
    endtask

    task automatic checkOutput(input int hold);
        int edges = 0;
        exp_t x;
        while (!out_valid && edges < 50) begin
            @(negedge clk);
            edges++;
        end
        check("latency_edges", edges, 8);
        x = sb_q.pop_front();
        check("diff", diff, {24'd0, x.diff});
        check("bout", bout, {31'd0, x.bout});
`ifdef SERIAL_SUB_FLAGS_EN
        check("zero", zero, {31'd0, x.zero});
        check("ovf", ovf, {31'd0, x.ovf});
`endif
        check("busy_done", busy, 1);
        check("in_ready_done", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_diff", diff, {24'd0, x.diff});
            check("bp_bout", bout, {31'd0, x.bout});
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_ack", out_valid, 0);
        check("in_ready_after_ack", in_ready, 1);
        check("busy_after_ack", busy, 0);
    endtask

    initial begin
        #23;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        check("rst_zero", zero, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1);

        applyStimulus(8'h05, 8'h03, 1'b0);
        checkOutput(0);
        applyStimulus(8'h03, 8'h05, 1'b0);
        checkOutput(0);
        applyStimulus(8'h00, 8'h00, 1'b1);
        checkOutput(0);
        applyStimulus(8'h10, 8'h10, 1'b0);
        checkOutput(0);
        applyStimulus(8'hA5, 8'h5A, 1'b1);
        checkOutput(5);

        // Abort after three RUN edges; reset must clear outputs without a clock edge.
        applyStimulus(8'h33, 8'h11, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        void'(sb_q.pop_back());
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_diff", diff, 0);
        check("abort_bout", bout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(8'h80, 8'h01, 1'b0);
        checkOutput(0);

        // WIDTH=1 instance with in_valid held high across RUN and DONE.
        e = model(1, 0, 1, 1'b0);
        c1_a = 1'b0;
        c1_b = 1'b1;
        c1_in_valid = 1'b1;
        @(negedge clk);
        check("w1_in_ready_run", c1_in_ready, 0);
        @(negedge clk);
        check("w1_out_valid", c1_out_valid, 1);
        check("w1_diff", c1_diff, {31'd0, e.diff[0]});
        check("w1_bout", c1_bout, {31'd0, e.bout});
`ifdef SERIAL_SUB_FLAGS_EN
        check("w1_zero", c1_zero, {31'd0, e.zero});
        check("w1_ovf", c1_ovf, {31'd0, e.ovf});
`endif
        c1_a = 1'b1;
        c1_b = 1'b0;
        repeat (2) @(negedge clk);
        check("w1_hold_diff", c1_diff, {31'd0, e.diff[0]});
        check("w1_hold_bout", c1_bout, {31'd0, e.bout});
        check("w1_hold_in_ready", c1_in_ready, 0);
        c1_out_ready = 1'b1;
        @(negedge clk);
        c1_out_ready = 1'b0;
        check("w1_idle_in_ready", c1_in_ready, 1);
        check("w1_idle_out_valid", c1_out_valid, 0);
        e = model(1, 1, 0, 1'b0);
        @(negedge clk);
        c1_in_valid = 1'b0;
        check("w1_second_accept", c1_in_ready, 0);
        @(negedge clk);
        check("w1_second_valid", c1_out_valid, 1);
        check("w1_second_diff", c1_diff, {31'd0, e.diff[0]});
        check("w1_second_bout", c1_bout, {31'd0, e.bout});
        c1_out_ready = 1'b1;
        @(negedge clk);
        c1_out_ready = 1'b0;
        check("w1_final_idle", c1_in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: observed hang expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
